// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtract path: FSM state encoding and default width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & (b ^ bin)) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: time-shares one full_subtractor over WIDTH cycles, LSB first.
// Optional zero/ovf flag outputs are enabled with macro SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d_bit, b_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .diff (d_bit),
    .bout (b_next)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Result word including the bit being produced this cycle; on the last SHIFT
  // edge this is the complete difference, so diff is valid alongside done.
  assign res_full = {d_bit, {(WIDTH-1){1'b0}}} | (res_sr >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_full;
          brw    <= b_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff <= res_full;
            bout <= b_next;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= (res_full == '0);
            ovf  <= (a_msb != b_msb) && (res_full[WIDTH-1] != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; borrow-out is the sign of the true result.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo,
                                output logic mz, output logic mo);
    int r;
    r   = int'(ma) - int'(mb) - int'(mbin);
    md  = W'(r);
    mbo = (r < 0);
    mz  = (md == '0);
    mo  = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
  endfunction

  // Issue one request, optionally scramble inputs after accept, wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                        input bit scramble,
                        output logic [W-1:0] d, output logic bo, output logic z, output logic o,
                        output int lat, output bit held);
    logic [W-1:0] prev;
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = diff;
    held = 1'b1;
    lat  = -1;
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (diff !== prev) held = 1'b0;
    end
    d  = diff;
    bo = bout;
`ifdef SERIAL_SUB_FLAGS_EN
    z = zero; o = ovf;
`else
    z = 1'b0; o = 1'b0;
`endif
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({ready, busy, done, diff, bout} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      $display("FAIL reset_state: rdy/busy/done/diff/bout got %b/%b/%b/%h/%b want 1/0/0/00/0",
               ready, busy, done, diff, bout);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One directed or random operation, fully checked.
  task automatic check_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic bini, input bit scramble);
    logic [W-1:0] d, ed;
    logic bo, z, o, ebo, ez, eo;
    int lat;
    bit held;
    model(ai, bi, bini, ed, ebo, ez, eo);
    run_op(ai, bi, bini, scramble, d, bo, z, o, lat, held);
    $display("%s: a=%h b=%h bin=%b -> diff=%h bout=%b lat=%0d", tag, ai, bi, bini, d, bo, lat);
    n_total++;
    if (lat !== W) $display("FAIL %s_latency: got %0d want %0d", tag, lat, W);
    else n_pass++;
    n_total++;
    if (!held) $display("FAIL %s_hold: diff changed before done (now %h)", tag, d);
    else n_pass++;
    n_total++;
    if ({d, bo} !== {ed, ebo}) $display("FAIL %s_result: diff/bout got %h/%b want %h/%b", tag, d, bo, ed, ebo);
    else n_pass++;
`ifdef SERIAL_SUB_FLAGS_EN
    n_total++;
    if ({z, o} !== {ez, eo}) $display("FAIL %s_flags: zero/ovf got %b/%b want %b/%b", tag, z, o, ez, eo);
    else n_pass++;
`endif
    @(posedge clk); #1;
    n_total++;
    if ({done, ready} !== 2'b01) $display("FAIL %s_ret_idle: done/ready got %b/%b want 0/1", tag, done, ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'hA7, 8'h00};
    logic [W-1:0] tb [6] = '{8'h12, 8'h35, 8'h00, 8'h01, 8'hA7, 8'hFF};
    logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) check_op($sformatf("dir%0d", i), ta[i], tb[i], tc[i], 1'b0);
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int lat = -1;
    @(negedge clk);
    a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++;
    if (lat !== W) $display("FAIL ignore_latency: got %0d want %0d", lat, W);
    else n_pass++;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    $display("ignore_start: diff=%h bout=%b extra_dones=%0d", diff, bout, dones);
    n_total++;
    if (dones !== 0) $display("FAIL ignore_extra_done: got %0d done pulses want 0", dones);
    else n_pass++;
    n_total++;
    if ({diff, bout, ready} !== {8'h30, 1'b0, 1'b1})
      $display("FAIL ignore_result: diff/bout/ready got %h/%b/%b want 30/0/1", diff, bout, ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int dones = 0;
    @(negedge clk);
    a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("async_reset: ready=%b busy=%b done=%b diff=%h bout=%b", ready, busy, done, diff, bout);
    n_total++;
    if ({ready, busy, done, diff, bout} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0})
      $display("FAIL async_reset_state: rdy/busy/done/diff/bout got %b/%b/%b/%h/%b want 1/0/0/00/0",
               ready, busy, done, diff, bout);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_total++;
    if (dones !== 0) $display("FAIL async_reset_no_done: got %0d done pulses want 0", dones);
    else n_pass++;
    check_op("post_reset", 8'h9C, 8'h3E, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int last = -1;
    int ndone = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ndone++;
        $display("b2b: done at cycle %0d diff=%h bout=%b", cyc, diff, bout);
        n_total++;
        if (last < 0 && cyc !== W + 1) $display("FAIL b2b_first: done cycle %0d want %0d", cyc, W + 1);
        else if (last >= 0 && cyc - last !== W + 2) $display("FAIL b2b_spacing: got %0d want %0d", cyc - last, W + 2);
        else n_pass++;
        n_total++;
        if ({diff, bout} !== {8'h00, 1'b0}) $display("FAIL b2b_result: diff/bout got %h/%b want 00/0", diff, bout);
        else n_pass++;
`ifdef SERIAL_SUB_FLAGS_EN
        n_total++;
        if ({zero, ovf} !== 2'b10) $display("FAIL b2b_flags: zero/ovf got %b/%b want 1/0", zero, ovf);
        else n_pass++;
`endif
        last = cyc;
      end
    end
    start = 1'b0;
    n_total++;
    if (ndone !== 4) $display("FAIL b2b_count: got %0d done pulses want 4", ndone);
    else n_pass++;
    for (int i = 0; i < 3 * W && !ready; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      check_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
